csr_file: RTL
=============

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file; the other end of the execution unit's CSR read-modify-write path.
//  - Supplies csr_r_data combinationally to the EXU.
//  - Accepts the EXU's computed new value at writeback.
//  - Performs trap entry (ecall) and trap return (mret).
//  - Runs the mcycle/minstret counters.
//  Sits beside the register file in the ID/WB stages.
// PARAMETERS
//  XLEN       64         data width; 32 or 64 only.
//  MHARTID    0          value returned by mhartid (0xF14).
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     synchronous reset, active-low
//  csr_addr     in   12    CSR address for read and write
//  csr_r_data   out  XLEN  combinational read data of csr_addr
//  csr_illegal  out  1     combinational: csr_addr unimplemented, or csr_w_en to a read-only CSR
//  csr_w_en     in   1     write csr_w_data to csr_addr at clock edge
//  csr_w_data   in   XLEN  new CSR value (EXU alu_result)
//  ecall        in   1     trap entry this cycle
//  mret         in   1     trap return this cycle
//  pc           in   XLEN  PC of the instruction raising ecall
//  inst_retire  in   1     one instruction retires this cycle
//  redirect_pc  out  XLEN  combinational: ecall -> {mtvec[XLEN-1:2],2'b00}; mret -> mepc; else 0
// BEHAVIOUR
//  Implemented CSRs:
//  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hard-wired 2'b11; all other bits read 0.
//  - mtvec 0x305: direct mode only; bits[1:0] are forced to 0 on write.
//  - mscratch 0x340: full width, read/write.
//  - mepc 0x341: bits[1:0] are forced to 0 on write.
//  - mcause 0x342: full width, read/write.
//  - mhartid 0xF14: read-only.
//  - Counter CSRs: see CONFIGURATION.
//  Unimplemented address:
//  - csr_r_data=0 and csr_illegal=1.
//  - A write to it is dropped.
//  - A write to a read-only CSR is dropped and csr_illegal=1.
//  Reset (rst_n=0 at clk edge): mstatus=0x1800; mtvec=mepc=mcause=mscratch=0; counters=0. Reset beats every other event.
//  Read: purely combinational from current state, 0-cycle latency. Read-during-write returns the OLD value; the new value is visible the next cycle.
//  Write: takes effect at the clk edge where csr_w_en=1.
//  ecall (one cycle, at the edge):
//  - mepc <= {pc[XLEN-1:2],2'b00}
//  - mcause <= 11
//  - MPIE <= MIE, then MIE <= 0
//  mret (one cycle, at the edge):
//  - MIE <= MPIE
//  - MPIE <= 1
//  Priority within one cycle: reset > ecall > mret > csr_w_en.
//  - ecall together with mret: only ecall is performed.
//  - ecall or mret together with csr_w_en: the CSR write is dropped entirely.
//  No internal FSM. Each edge is an independent update; no multi-cycle operations.
// CONFIGURATION
//  Macro CSR_COUNTERS_EN.
//  Defined:
//  - 64-bit mcycle 0xB00 increments every cycle out of reset.
//  - 64-bit minstret 0xB02 increments when inst_retire=1.
//  - Both wrap from 2^64-1 to 0.
//  - Both are writable. A write in the same cycle replaces that cycle's increment: the counter takes exactly csr_w_data.
//  - When XLEN=32: the low 32 bits are at 0xB00/0xB02 and the high halves at mcycleh 0xB80 / minstreth 0xB82.
//    A half-write updates only that half and suppresses that cycle's increment.
//  - When XLEN=64: 0xB80/0xB82 are unimplemented.
//  Undefined: no counter registers; 0xB00/0xB02/0xB80/0xB82 are unimplemented (read 0, csr_illegal=1); inst_retire is ignored.
// TESTING
//  1. Reset, then read 0x300 -> 0x1800. Read 0x305/0x341 -> 0. Read 0x7C0 -> data 0, csr_illegal=1.
//  2. Write 0x305=0x8000_0003 -> reads back 0x8000_0000. Next cycle ecall with pc=0x8000_0104 ->
//     redirect_pc=0x8000_0000; after the edge mepc=0x8000_0104, mcause=11, MIE=0.
//  3. Write mstatus=0x8 (MIE=1), then ecall -> mstatus=0x1880. Then mret -> redirect_pc=mepc, mstatus=0x1888.
//  4. In one cycle, csr_w_en to mscratch=0x55 with ecall=1 -> mscratch unchanged and ecall state updated.
//     A read of mscratch in the write cycle returns the old value.
//  5. [CSR_COUNTERS_EN] Write mcycle=0xFFFF_FFFF_FFFF_FFFE -> reads ...FFFE next cycle, 0xFFFF_FFFF_FFFF_FFFF the cycle after, 0 after that.
//     Three inst_retire pulses with one concurrent minstret write of 0x10 on the second pulse -> minstret=0x11.
//  6. rst_n=0 for one cycle mid-sequence (counters running, mepc set) -> every register returns to its reset value at that edge.
//     Without CSR_COUNTERS_EN, read of 0xB00 -> 0 with csr_illegal=1.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR register file: combinational read port, writeback write port,
// ecall trap entry, mret trap return and (optionally) the mcycle/minstret counters.
// Optional feature macro: CSR_COUNTERS_EN (adds mcycle/minstret and, for XLEN=32,
// their high halves mcycleh/minstreth).
module csr_file #(
  parameter int unsigned XLEN    = 64,
  parameter logic [63:0] MHARTID = 64'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_r_data,
  output logic            csr_illegal,
  input  logic            csr_w_en,
  input  logic [XLEN-1:0] csr_w_data,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic            inst_retire,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMhartid  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  // High-half aliases only exist on 32-bit harts.
  localparam bit          HasHighHalf   = (XLEN == 32);
`endif

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;
`endif

  logic [XLEN-1:0] mstatus_rd;
  logic            implemented;
  logic            read_only;
  logic            wr;

  // mstatus view: MPP hard-wired to M-mode, only MIE/MPIE are live.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  // Address decode and read mux from current state.
  always_comb begin
    csr_r_data  = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr)
      AddrMstatus:  csr_r_data = mstatus_rd;
      AddrMtvec:    csr_r_data = mtvec_q;
      AddrMscratch: csr_r_data = mscratch_q;
      AddrMepc:     csr_r_data = mepc_q;
      AddrMcause:   csr_r_data = mcause_q;
      AddrMhartid: begin
        csr_r_data = MHARTID[XLEN-1:0];
        read_only  = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      AddrMcycle:   csr_r_data = mcycle_q[XLEN-1:0];
      AddrMinstret: csr_r_data = minstret_q[XLEN-1:0];
      AddrMcycleh: begin
        if (HasHighHalf) csr_r_data = XLEN'(mcycle_q[63:32]);
        else             implemented = 1'b0;
      end
      AddrMinstreth: begin
        if (HasHighHalf) csr_r_data = XLEN'(minstret_q[63:32]);
        else             implemented = 1'b0;
      end
`endif
      default:      implemented = 1'b0;
    endcase
  end

  assign csr_illegal = !implemented || (csr_w_en && read_only);

  // Trap target: direct-mode mtvec on ecall, saved mepc on mret.
  always_comb begin
    redirect_pc = '0;
    if (ecall)     redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
    else if (mret) redirect_pc = mepc_q;
  end

  // A software write only lands when no trap event claims this edge.
  assign wr = csr_w_en && implemented && !read_only && !ecall && !mret;

  // Next-state: ecall > mret > CSR write; counters tick unless overwritten.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, inst_retire};
`endif
    if (ecall) begin
      mepc_d   = {pc[XLEN-1:2], 2'b00};
      mcause_d = XLEN'(11);
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr) begin
      case (csr_addr)
        AddrMstatus: begin
          mie_d  = csr_w_data[3];
          mpie_d = csr_w_data[7];
        end
        AddrMtvec:    mtvec_d    = {csr_w_data[XLEN-1:2], 2'b00};
        AddrMscratch: mscratch_d = csr_w_data;
        AddrMepc:     mepc_d     = {csr_w_data[XLEN-1:2], 2'b00};
        AddrMcause:   mcause_d   = csr_w_data;
`ifdef CSR_COUNTERS_EN
        AddrMcycle: begin
          if (HasHighHalf) mcycle_d = {mcycle_q[63:32], csr_w_data[31:0]};
          else             mcycle_d = 64'(csr_w_data);
        end
        AddrMinstret: begin
          if (HasHighHalf) minstret_d = {minstret_q[63:32], csr_w_data[31:0]};
          else             minstret_d = 64'(csr_w_data);
        end
        AddrMcycleh:   mcycle_d   = {csr_w_data[31:0], mcycle_q[31:0]};
        AddrMinstreth: minstret_d = {csr_w_data[31:0], minstret_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset that overrides every other event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

  // pc is word-aligned on trap entry; retire strobe has no sink without counters.
`ifdef CSR_COUNTERS_EN
  logic unused_inputs;
  assign unused_inputs = ^pc[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{pc[1:0], inst_retire};
`endif

endmodule
